uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Scheduler that shares the single UART transmitter between two requesters: register-file read data (8-bit) and ALU result (16-bit, sent as two bytes, LSB first). It arbitrates round-robin and captures the winner's payload. It then sequences the transmitter through its DATA_VALID/Busy handshake byte by byte. A watchdog flags a transmitter that never acknowledges. Sits between SYS_CTRL-side producers and the UART TX, in the UART TX clock domain.

Parameters:
DATA_WIDTH, 8, byte width on the UART interface
BUSY_TO, 16, max cycles to wait for TX_BUSY to rise after a TX_D_VLD pulse (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
RF_RD_DATA  in  DATA_WIDTH  register-file read byte
RF_RD_VLD  in  1  level request; data held stable until RF_ACK
RF_ACK  out  1  one-cycle pulse; RF payload captured
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  level request; data held stable until ALU_ACK
ALU_ACK  out  1  one-cycle pulse; ALU payload captured
TX_BUSY  in  1  UART transmitter busy
TX_P_DATA  out  DATA_WIDTH  byte to UART; stable from pulse until byte completes
TX_D_VLD  out  1  one-cycle start pulse to UART
SCHED_BUSY  out  1  high whenever state != IDLE
TO_ERR  out  1  sticky watchdog error
TO_ERR_CLR  in  1  clears TO_ERR

Behaviour:
- All outputs registered. On reset: state=IDLE, RF_ACK=ALU_ACK=0, TX_D_VLD=0, TX_P_DATA=0, SCHED_BUSY=0, TO_ERR=0, last_grant=ALU (so RF wins the first tie), byte counter=0, watchdog=0.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: sampled at the edge.
  - One VLD high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - On the grant edge: capture the payload into a 16-bit holding reg (RF zero-extended), set nbytes (RF=1, ALU=2), pulse the matching ACK for exactly one cycle, update last_grant, go to SEND.
  - No VLD: stay in IDLE.
- SEND:
  - TX_BUSY=0: TX_P_DATA<=current byte (byte0=bits[7:0], byte1=bits[15:8]), TX_D_VLD<=1 for one cycle, watchdog cleared, go to WAIT_BUSY.
  - TX_BUSY=1: hold in SEND with no pulse.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Otherwise increment the watchdog; when it reaches BUSY_TO-1 with TX_BUSY still 0: set TO_ERR, drop the remaining bytes, go to IDLE.
- WAIT_DONE: on TX_BUSY=0, advance the byte counter. If bytes remain, go to SEND (next byte); else go to IDLE.
- Latency: grant at edge E0, so the ACK is high in cycle E0..E1. First TX_D_VLD is high in cycle E1..E2 if TX_BUSY=0. Between ALU bytes: the TX_BUSY fall is seen at edge F, state is SEND after F, and the second pulse is set at F+1.
- Requests are never sampled outside IDLE; a VLD raised mid-transfer waits. The requester must drop VLD after seeing ACK.
- TO_ERR: if TO_ERR_CLR and the set condition coincide, set wins. Clear takes effect next cycle otherwise.
- TX_P_DATA is not reset to 0 between transfers; it holds the last byte.
- Async RST mid-transfer: immediately returns to reset values; a partial ALU transfer is lost (no resume).

Decomposition:
- Package uart_tx_sched_pkg: state enum (2-bit), channel id constants CH_RF=0 and CH_ALU=1, BYTES_RF=1, BYTES_ALU=2.
- Sub-module rr_arb2: 2-request round-robin arbiter, combinational grant plus registered last_grant pointer. Instantiated once.
- Watchdog counter width: $clog2(BUSY_TO).

Test Plan:
- RF only: RF_RD_DATA=0xA5, RF_RD_VLD=1 with a UART model (Busy 1 cycle after pulse, 10 cycles long) -> RF_ACK one pulse; one TX_D_VLD with TX_P_DATA=0xA5; SCHED_BUSY falls after Busy falls.
- ALU only: ALU_OUT=0x1234 -> two TX_D_VLD pulses, bytes 0x34 then 0x12; second pulse only after TX_BUSY fell; ALU_ACK exactly once.
- Simultaneous: both VLD high from reset (RF=0x11, ALU=0xBEEF), each requester dropping VLD after its ACK then re-requesting with new data -> RF served first (0x11), then ALU (0xEF, 0xBE), then RF again; round-robin alternation holds for 4 rounds.
- Busy in SEND: TX_BUSY held 1 when entering SEND -> no pulse until TX_BUSY=0, then a pulse the next cycle.
- Watchdog: model never raises Busy, BUSY_TO=16 -> TO_ERR set 16 cycles after the pulse and state returns to IDLE. TO_ERR_CLR asserted alone -> TO_ERR clears. TO_ERR_CLR coincident with a second timeout -> TO_ERR stays 1.
- Reset mid-ALU transfer: assert RST between byte0 and byte1 -> all outputs return to reset values; no second pulse; the next request is accepted normally.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Channel ids, byte counts and the scheduler state encoding.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  localparam logic CH_RF  = 1'b0;
  localparam logic CH_ALU = 1'b1;

  localparam logic [1:0] BYTES_RF  = 2'd1;
  localparam logic [1:0] BYTES_ALU = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant,
// registered pointer to the last granted channel.
module rr_arb2
  import uart_tx_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_vld_o,
  output logic       gnt_ch_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_ch_o  = CH_RF;
    unique case (req_i)
      2'b11:   gnt_ch_o = ~last_q;
      2'b10:   gnt_ch_o = CH_ALU;
      default: gnt_ch_o = CH_RF;
    endcase
    last_d = (take_i && gnt_vld_o) ? gnt_ch_o : last_q;
  end

  // Reset to ALU so RF wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= CH_ALU;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between RF (1 byte) and ALU (2 bytes)
// requesters, with a watchdog on the transmitter busy handshake.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TO    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    RF_ACK,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    ALU_ACK,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    SCHED_BUSY,
  output logic                    TO_ERR,
  input  logic                    TO_ERR_CLR
);

  localparam int HW  = 2 * DATA_WIDTH;
  localparam int WDW = $clog2(BUSY_TO);
  localparam logic [WDW-1:0] WD_MAX = WDW'(BUSY_TO - 1);

  state_e                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [1:0]            nbytes_q, nbytes_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  rf_ack_q, rf_ack_d;
  logic                  alu_ack_q, alu_ack_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic                  to_err_q, to_err_d;

  logic                  gnt_vld;
  logic                  gnt_ch;
  logic                  take;
  logic                  to_set;
  logic [DATA_WIDTH-1:0] cur_byte;

  assign take = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .req_i     ({ALU_OUT_VLD, RF_RD_VLD}),
    .take_i    (take),
    .gnt_vld_o (gnt_vld),
    .gnt_ch_o  (gnt_ch)
  );

  assign cur_byte = bcnt_q[0] ? hold_q[HW-1:DATA_WIDTH]
                              : hold_q[DATA_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    nbytes_d  = nbytes_q;
    bcnt_d    = bcnt_q;
    wd_d      = wd_q;
    rf_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    to_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          bcnt_d  = '0;
          state_d = ST_SEND;
          if (gnt_ch == CH_RF) begin
            hold_d   = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            nbytes_d = BYTES_RF;
            rf_ack_d = 1'b1;
          end else begin
            hold_d    = ALU_OUT;
            nbytes_d  = BYTES_ALU;
            alu_ack_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (!TX_BUSY) begin
          tx_data_d = cur_byte;
          tx_vld_d  = 1'b1;
          wd_d      = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_q == WD_MAX) begin
          // Transmitter never acknowledged: abandon the rest.
          to_set  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          bcnt_d  = bcnt_q + 2'd1;
          state_d = (bcnt_q + 2'd1 < nbytes_q) ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    to_err_d = (to_err_q & ~TO_ERR_CLR) | to_set;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      nbytes_q  <= '0;
      bcnt_q    <= '0;
      wd_q      <= '0;
      rf_ack_q  <= 1'b0;
      alu_ack_q <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      nbytes_q  <= nbytes_d;
      bcnt_q    <= bcnt_d;
      wd_q      <= wd_d;
      rf_ack_q  <= rf_ack_d;
      alu_ack_q <= alu_ack_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      to_err_q  <= to_err_d;
    end
  end

  assign RF_ACK     = rf_ack_q;
  assign ALU_ACK    = alu_ack_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign SCHED_BUSY = busy_q;
  assign TO_ERR     = to_err_q;

endmodule
